codec_reg_arbiter: RTL and testbench

- Shares the single TWI (I2C) byte controller between two register-write requesters.
  - Requester 0 is the codec init sequencer.
  - Requester 1 is the runtime control path (volume, mute, mixer changes).
- Each accepted request is one ADAU1761 register write. It is sequenced onto TWI as: register address high byte (with new-message), register address low byte, data byte.
- Handles retries on TWI error, inserts an inter-transaction gap, and returns a per-requester completion response.

---
 rtl/codec_reg_arbiter.sv | 173 +++++++++++++++++
 tb/tb_codec_reg_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/codec_reg_arbiter.sv
// Two-requester arbiter that turns 16-bit-address codec register writes into TWI byte sequences.
// Optional round-robin arbitration is enabled by defining CODEC_ARB_ROUND_ROBIN_EN.
module codec_reg_arbiter #(
  parameter logic [6:0]  DEV_ADDR   = 7'h3B,
  parameter int unsigned GAP_CYCLES = 24000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_data,
  output logic        resp0_valid,
  output logic        resp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_data,
  output logic        resp1_valid,
  output logic        resp1_err,
  output logic        twi_msg,
  output logic        twi_stb,
  output logic [7:0]  twi_addr,
  output logic [7:0]  twi_data,
  input  logic        twi_done,
  input  logic        twi_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, GAP, RESP} state_t;
  typedef enum logic [1:0] {OUT_OK, OUT_RETRY, OUT_FAIL} outcome_t;

  localparam logic [19:0] GAP_LOAD  = 20'(GAP_CYCLES);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      state_reg, state_next;
  outcome_t    outcome_reg, outcome_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        owner_reg, owner_next;
  logic [3:0]  retry_reg, retry_next;
  logic [19:0] gap_reg, gap_next;
  logic        stb_reg, stb_next, msg_reg, msg_next;
  logic [7:0]  twi_data_reg, twi_data_next;
  logic        resp0_valid_reg, resp0_valid_next, resp0_err_reg, resp0_err_next;
  logic        resp1_valid_reg, resp1_valid_next, resp1_err_reg, resp1_err_next;
  logic        idle, grant0, grant1, accept, byte_state;

  assign idle = (state_reg == IDLE);

`ifdef CODEC_ARB_ROUND_ROBIN_EN
  // prio1_reg set means requester 1 wins a tie (requester 0 was granted last)
  logic prio1_reg;
  always_ff @(posedge clk) begin
    if (!rst_n)      prio1_reg <= 1'b0;
    else if (accept) prio1_reg <= req0_ready;
  end
  assign grant0 = req0_valid && !(prio1_reg && req1_valid);
  assign grant1 = req1_valid && !(!prio1_reg && req0_valid);
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid && !req0_valid;
`endif

  assign req0_ready = idle && grant0;
  assign req1_ready = idle && grant1;
  assign accept     = req0_ready || req1_ready;
  assign byte_state = (state_reg == ADDR_HI) || (state_reg == ADDR_LO) || (state_reg == DATA);

  always_comb begin
    state_next   = state_reg;
    outcome_next = outcome_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    owner_next   = owner_reg;
    retry_next   = retry_reg;
    gap_next     = gap_reg;
    case (state_reg)
      IDLE: if (accept) begin
        state_next = ADDR_HI;
        owner_next = req1_ready;
        addr_next  = req1_ready ? req1_addr : req0_addr;
        data_next  = req1_ready ? req1_data : req0_data;
        retry_next = 4'd0;
      end
      ADDR_HI: if (twi_done && !twi_err) state_next = ADDR_LO;
      ADDR_LO: if (twi_done && !twi_err) state_next = DATA;
      DATA: if (twi_done && !twi_err) begin
        outcome_next = OUT_OK;
        state_next   = GAP;
        gap_next     = GAP_LOAD;
      end
      GAP: begin
        if (gap_reg == 20'd0) state_next = (outcome_reg == OUT_RETRY) ? ADDR_HI : RESP;
        else                  gap_next   = gap_reg - 20'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Any byte error ends the attempt; the gap is observed before retry or response
    if (byte_state && twi_done && twi_err) begin
      if (retry_reg < RETRY_MAX) begin
        retry_next   = retry_reg + 4'd1;
        outcome_next = OUT_RETRY;
      end else begin
        outcome_next = OUT_FAIL;
      end
      state_next = GAP;
      gap_next   = GAP_LOAD;
    end

    stb_next      = (state_next == ADDR_HI) || (state_next == ADDR_LO) || (state_next == DATA);
    msg_next      = (state_next == ADDR_HI);
    twi_data_next = twi_data_reg;
    case (state_next)
      ADDR_HI: twi_data_next = addr_next[15:8];
      ADDR_LO: twi_data_next = addr_next[7:0];
      DATA:    twi_data_next = data_next;
      default: twi_data_next = twi_data_reg;
    endcase
    resp0_valid_next = (state_next == RESP) && !owner_next;
    resp1_valid_next = (state_next == RESP) && owner_next;
    resp0_err_next   = resp0_valid_next && (outcome_next == OUT_FAIL);
    resp1_err_next   = resp1_valid_next && (outcome_next == OUT_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      outcome_reg     <= OUT_OK;
      addr_reg        <= 16'd0;
      data_reg        <= 8'd0;
      owner_reg       <= 1'b0;
      retry_reg       <= 4'd0;
      gap_reg         <= 20'd0;
      stb_reg         <= 1'b0;
      msg_reg         <= 1'b0;
      twi_data_reg    <= 8'd0;
      resp0_valid_reg <= 1'b0;
      resp0_err_reg   <= 1'b0;
      resp1_valid_reg <= 1'b0;
      resp1_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      outcome_reg     <= outcome_next;
      addr_reg        <= addr_next;
      data_reg        <= data_next;
      owner_reg       <= owner_next;
      retry_reg       <= retry_next;
      gap_reg         <= gap_next;
      stb_reg         <= stb_next;
      msg_reg         <= msg_next;
      twi_data_reg    <= twi_data_next;
      resp0_valid_reg <= resp0_valid_next;
      resp0_err_reg   <= resp0_err_next;
      resp1_valid_reg <= resp1_valid_next;
      resp1_err_reg   <= resp1_err_next;
    end
  end

  assign twi_stb     = stb_reg;
  assign twi_msg     = msg_reg;
  assign twi_data    = twi_data_reg;
  assign twi_addr    = {DEV_ADDR, 1'b0};
  assign resp0_valid = resp0_valid_reg;
  assign resp0_err   = resp0_err_reg;
  assign resp1_valid = resp1_valid_reg;
  assign resp1_err   = resp1_err_reg;
  assign busy        = !idle;

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// Directed scoreboard bench for codec_reg_arbiter: TWI byte order, retries, gap latency, arbitration, reset abort.
module tb_codec_reg_arbiter;
  localparam int GAP = 8;
  localparam int MR  = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic        twi_msg, twi_stb, twi_done = 1'b0, twi_err = 1'b0, busy;
  logic [7:0]  twi_addr, twi_data;

  int checks = 0, failures = 0;
  int resp_seen = 0, resp_waited = 0;
  logic [8:0] exp_bytes[$];
  logic [1:0] exp_resp[$];

  codec_reg_arbiter #(.DEV_ADDR(7'h3B), .GAP_CYCLES(GAP), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .resp0_valid(resp0_valid), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .resp1_valid(resp1_valid), .resp1_err(resp1_err),
    .twi_msg(twi_msg), .twi_stb(twi_stb), .twi_addr(twi_addr), .twi_data(twi_data),
    .twi_done(twi_done), .twi_err(twi_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && (resp0_valid || resp1_valid)) resp_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_write(input logic [15:0] a, input logic [7:0] d);
    exp_bytes.push_back({1'b1, a[15:8]});
    exp_bytes.push_back({1'b0, a[7:0]});
    exp_bytes.push_back({1'b0, d});
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    logic [8:0] e;
    while (twi_stb !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_stb"}, 32'(twi_stb), 1);
    e = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 9'h1FF;
    chk({tag, "_byte"}, {23'd0, twi_msg, twi_data}, {23'd0, e});
    $display("byte %s msg=%0b data=%02h", tag, twi_msg, twi_data);
  endtask

  task automatic do_byte(input string tag, input bit err);
    wait_stb(tag);
    @(negedge clk);
    twi_done = 1'b1; twi_err = err;
    @(negedge clk);
    twi_done = 1'b0; twi_err = 1'b0;
  endtask

  task automatic wait_resp(input string tag, output int cyc);
    logic [1:0] e;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(resp0_valid || resp1_valid) && cyc < 2000);
    e = (exp_resp.size() > 0) ? exp_resp.pop_front() : 2'b11;
    resp_waited++;
    chk({tag, "_resp"}, {29'd0, resp1_valid, resp0_valid, (resp0_valid ? resp0_err : resp1_err)},
        {29'd0, e[1], !e[1], e[0]});
    chk({tag, "_resp_rdy"}, {30'd0, req1_ready, req0_ready}, 0);
    $display("resp %s owner=%0d err=%0b after %0d cycles", tag, resp1_valid, resp0_err | resp1_err, cyc);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, {30'd0, resp1_valid, resp0_valid}, 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic issue(input bit owner, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    if (owner) begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    else       begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    #1;
    while (!(owner ? req1_ready : req0_ready) && n < 2000) begin @(negedge clk); #1; n++; end
    chk("issue_ready", 32'(owner ? req1_ready : req0_ready), 1);
    @(negedge clk);
    // scramble inputs after acceptance; the transaction must be unaffected
    if (owner) begin req1_valid = 1'b0; req1_addr = 16'hDEAD; req1_data = 8'h5A; end
    else       begin req0_valid = 1'b0; req0_addr = 16'hBEEF; req0_data = 8'hA5; end
    chk("accept_lat_stb", 32'(twi_stb), 1);
  endtask

  task automatic sim_pair(input bit first, input logic [15:0] a0, input logic [7:0] d0,
                          input logic [15:0] a1, input logic [7:0] d1);
    int cyc;
    if (first) begin push_write(a1, d1); push_write(a0, d0); exp_resp.push_back(2'b10); exp_resp.push_back(2'b00); end
    else       begin push_write(a0, d0); push_write(a1, d1); exp_resp.push_back(2'b00); exp_resp.push_back(2'b10); end
    req0_valid = 1'b1; req0_addr = a0; req0_data = d0;
    req1_valid = 1'b1; req1_addr = a1; req1_data = d1;
    #1;
    chk("sim_ready0", 32'(req0_ready), 32'(!first));
    chk("sim_ready1", 32'(req1_ready), 32'(first));
    @(negedge clk);
    if (first) req1_valid = 1'b0; else req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) do_byte("sim_w", 1'b0);
    chk("sim_loser_wait", 32'(first ? req0_ready : req1_ready), 0);
    wait_resp("sim_w", cyc);
    chk("sim_loser_ready", 32'(first ? req0_ready : req1_ready), 1);
    @(negedge clk);
    if (first) req0_valid = 1'b0; else req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) do_byte("sim_l", 1'b0);
    wait_resp("sim_l", cyc);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_stb", 32'(twi_stb), 0);
    chk("rst_msg", 32'(twi_msg), 0);
    chk("rst_data", 32'(twi_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp", {28'd0, resp1_valid, resp1_err, resp0_valid, resp0_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("twi_addr", 32'(twi_addr), 32'h76);

    // single write from requester 1 with gap latency
    push_write(16'h4023, 8'hE7); exp_resp.push_back(2'b10);
    issue(1'b1, 16'h4023, 8'hE7);
    for (int i = 0; i < 3; i++) do_byte("single", 1'b0);
    wait_resp("single", cyc);
    chk("single_latency", 32'(cyc), 32'(GAP + 1));

    // simultaneous: requester 0 wins under both policies here (requester 1 granted last)
    sim_pair(1'b0, 16'h4000, 8'h0E, 16'h4025, 8'hE6);

    // one error on ADDR_LO, then a clean retry
    exp_bytes.push_back({1'b1, 8'h40}); exp_bytes.push_back({1'b0, 8'h15});
    push_write(16'h4015, 8'h01); exp_resp.push_back(2'b00);
    issue(1'b0, 16'h4015, 8'h01);
    do_byte("retry_hi", 1'b0);
    do_byte("retry_lo", 1'b1);
    chk("retry_gap_stb", 32'(twi_stb), 0);
    chk("retry_gap_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) do_byte("retry2", 1'b0);
    wait_resp("retry", cyc);

    // persistent error on ADDR_HI with stray done pulses during the gaps
    for (int i = 0; i < MR + 1; i++) exp_bytes.push_back({1'b1, 8'h40});
    exp_resp.push_back(2'b01);
    issue(1'b0, 16'h4016, 8'h02);
    for (int i = 0; i < MR + 1; i++) begin
      do_byte("persist", 1'b1);
      if (i < MR) begin
        twi_done = 1'b1; twi_err = 1'b1;
        @(negedge clk);
        twi_done = 1'b0; twi_err = 1'b0;
        chk("persist_gap_stb", 32'(twi_stb), 0);
      end
    end
    wait_resp("persist", cyc);
    chk("persist_no_stb", 32'(twi_stb), 0);

    // simultaneous after requester 0 was granted last
`ifdef CODEC_ARB_ROUND_ROBIN_EN
    sim_pair(1'b1, 16'h40F0, 8'hAA, 16'h40F1, 8'h55);
`else
    sim_pair(1'b0, 16'h40F0, 8'hAA, 16'h40F1, 8'h55);
`endif

    // stray done while idle
    twi_done = 1'b1; twi_err = 1'b1;
    @(negedge clk);
    twi_done = 1'b0; twi_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_idle_busy", 32'(busy), 0);
    chk("stray_idle_stb", 32'(twi_stb), 0);

    // reset during DATA aborts without a response
    push_write(16'h4030, 8'h11);
    issue(1'b1, 16'h4030, 8'h11);
    do_byte("abort_hi", 1'b0);
    do_byte("abort_lo", 1'b0);
    wait_stb("abort_data");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_stb", 32'(twi_stb), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (GAP + 6) @(negedge clk);
    chk("abort_still_idle", 32'(busy), 0);

    push_write(16'h4031, 8'h22); exp_resp.push_back(2'b00);
    issue(1'b0, 16'h4031, 8'h22);
    for (int i = 0; i < 3; i++) do_byte("post_rst", 1'b0);
    wait_resp("post_rst", cyc);

    repeat (2) @(negedge clk);
    chk("resp_count", 32'(resp_seen), 32'(resp_waited));
    chk("bytes_left", 32'(exp_bytes.size()), 0);
    chk("resps_left", 32'(exp_resp.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
